lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/memory_pkg.sv | 18 +
 rtl/lsu_load_fmt.sv | 32 +++
 rtl/lsu.sv | 135 +++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared memory-system constants: data memory size, LSU size codes and LSU FSM states.
package memory_pkg;

  localparam int unsigned DATA_MEM_SIZE_BYTES = 2048;

  // Load/store size codes as carried on core_size_i; 3, 6 and 7 are unused.
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    StIdle,
    StWait
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_fmt.sv
// Load-data formatter: picks the addressed byte/half of a memory word and extends it.
module lsu_load_fmt
  import memory_pkg::*;
(
  input  logic        valid_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then sign/zero extension; zero whenever the result is not being consumed.
  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = '0;
    if (valid_i) begin
      case (size_i)
        LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
        LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
        LDST_W:  data_o = rdata_i;
        LDST_BU: data_o = {24'h0, byte_sel};
        LDST_HU: data_o = {16'h0, half_sel};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: checks a core access, latches it, and runs one memory handshake per access.
module lsu
  import memory_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = DATA_MEM_SIZE_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wd_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        legal;
  logic        latch_en;
  logic        rd_valid;
  logic [3:0]  be_w;

  // Access legality: known size code, no unsigned stores, natural alignment, inside the window.
  always_comb begin
    legal = 1'b1;
    case (core_size_i)
      LDST_B:  legal = 1'b1;
      LDST_H:  legal = ~core_addr_i[0];
      LDST_W:  legal = (core_addr_i[1:0] == 2'b00);
      LDST_BU: legal = ~core_we_i;
      LDST_HU: legal = ~core_we_i & ~core_addr_i[0];
      default: legal = 1'b0;
    endcase
    if (core_addr_i >= DMEM_BYTES) begin
      legal = 1'b0;
    end
  end

  // Byte enables and replicated store data derived from the latched access.
  always_comb begin
    case (size_q)
      LDST_B, LDST_BU: be_w = 4'b0001 << addr_q[1:0];
      LDST_H, LDST_HU: be_w = 4'b0011 << addr_q[1:0];
      default:         be_w = 4'b1111;
    endcase
    case (size_q)
      LDST_B:  mem_wd_o = {4{wd_q[7:0]}};
      LDST_H:  mem_wd_o = {2{wd_q[15:0]}};
      default: mem_wd_o = wd_q;
    endcase
    mem_addr_o = {addr_q[31:2], 2'b00};
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    rd_valid     = 1'b0;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (core_req_i) begin
          if (legal) begin
            latch_en     = 1'b1;
            core_stall_o = 1'b1;
            state_d      = StWait;
          end else begin
            core_err_o = 1'b1;
          end
        end
      end
      StWait: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
        mem_be_o  = be_w;
        if (mem_ready_i) begin
          rd_valid = 1'b1;
          state_d  = StIdle;
        end else begin
          core_stall_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Access latch, loaded only when a legal request is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      wd_q   <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
    end else if (latch_en) begin
      addr_q <= core_addr_i;
      wd_q   <= core_wd_i;
      size_q <= core_size_i;
      we_q   <= core_we_i;
    end
  end

  lsu_load_fmt u_load_fmt (
    .valid_i  (rd_valid),
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .rdata_i  (mem_rd_i),
    .data_o   (core_rd_o)
  );

endmodule
